// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ valid/ready producers.
// Each grant covers a burst of up to MAX_BURST words and is followed by one idle cycle.
module fifo_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*DW-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    input  logic                  full,
    output logic                  wr_en,
    output logic [DW-1:0]         wr_data,
    output logic [N_REQ-1:0]      grant,
    output logic                  busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int BC_W  = $clog2(MAX_BURST) + 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [PTR_W-1:0]   r_ptr;
    logic [BC_W-1:0]    r_burst_cnt;

    logic               w_owner_valid;
    logic               w_accept;
    logic [PTR_W-1:0]   w_owner;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [PTR_W-1:0]   w_sel;
    logic [DW-1:0]      w_data;
    int                 w_best;
    int                 w_dist;

    assign w_owner_valid = |(r_grant & req_valid);
    assign w_accept      = w_owner_valid & ~full;
    assign req_ready     = r_grant & {N_REQ{~full}};
    assign wr_en         = w_accept;
    assign wr_data       = w_data;
    assign grant         = r_grant;
    assign busy          = (r_state == GRANT);

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        w_owner = '0;
        w_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_grant[k]) begin
                w_owner = PTR_W'(k);
                w_data  = req_data[k*DW +: DW];
            end
        end
    end

    assign w_next_ptr = (int'(w_owner) == N_REQ - 1) ? '0 : w_owner + PTR_W'(1);

    // Pick the valid requester closest to r_ptr going upward with wrap-around.
    always_comb begin
        w_sel  = '0;
        w_best = N_REQ;
        w_dist = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_dist = (k >= int'(r_ptr)) ? k - int'(r_ptr) : k + N_REQ - int'(r_ptr);
            if (req_valid[k] && w_dist < w_best) begin
                w_best = w_dist;
                w_sel  = PTR_W'(k);
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments only.
    always_ff @(posedge wclk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_grant     <= N_REQ'(1) << w_sel;
                        r_burst_cnt <= '0;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    // A full stall keeps the grant and the count; only a drop or the last beat releases.
                    if (!w_owner_valid || (w_accept && r_burst_cnt == LAST_BEAT)) begin
                        r_state     <= IDLE;
                        r_grant     <= '0;
                        r_burst_cnt <= '0;
                        r_ptr       <= w_next_ptr;
                    end else if (w_accept) begin
                        r_burst_cnt <= r_burst_cnt + BC_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
